// File: rtl/axi4_stream_checker_pkg.sv
// Shared constants for the AXI4-Stream checker: register offsets, CTRL/STATUS
// field positions and FSM state encoding.
package axi4_stream_pkg;

   localparam logic [2:0] REG_CTRL      = 3'd0;
   localparam logic [2:0] REG_EXP_LEN   = 3'd1;
   localparam logic [2:0] REG_SEED      = 3'd2;
   localparam logic [2:0] REG_BEAT_CNT  = 3'd3;
   localparam logic [2:0] REG_PKT_CNT   = 3'd4;
   localparam logic [2:0] REG_ERR_CNT   = 3'd5;
   localparam logic [2:0] REG_STATUS    = 3'd6;
   localparam logic [2:0] REG_FIRST_ERR = 3'd7;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_CLR     = 1;
   localparam int CTRL_STOP    = 2;
   localparam int CTRL_THR_LSB = 8;
   localparam int CTRL_THR_MSB = 15;

   localparam int STAT_HALTED    = 0;
   localparam int STAT_DATA_ERR  = 1;
   localparam int STAT_LEN_ERR   = 2;
   localparam int STAT_TID_LSB   = 8;
   localparam int STAT_TDEST_LSB = 16;
   localparam int STAT_TKEEP_LSB = 20;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/axi4_stream_checker_apb_csr.sv
// APB slave for the stream checker: decode, control/config storage and read mux.
// Every access takes exactly one wait state; pready and prdata are registered.
module apb_csr_checker
   import axi4_stream_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
)(
   input  logic              ACLK,
   input  logic              RSTN,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [31:0]       paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              en,
   output logic              clr,
   output logic              stop_on_err,
   output logic [7:0]        thr,
   output logic [31:0]       exp_len,
   output logic [DATA_W-1:0] seed,
   input  logic [CNT_W-1:0]  beat_cnt,
   input  logic [CNT_W-1:0]  pkt_cnt,
   input  logic [CNT_W-1:0]  err_cnt,
   input  logic [31:0]       status,
   input  logic [DATA_W-1:0] first_err
);

   logic [2:0]  reg_sel;
   logic        access;
   logic        wr_stb;
   logic        rd_stb;
   logic [31:0] rdata;
   logic        unused_apb;

   assign reg_sel    = paddr[4:2];
   assign access     = psel & penable;
   assign wr_stb     = access & pready & pwrite;
   assign rd_stb     = access & ~pready & ~pwrite;
   assign pslverr    = 1'b0;
   assign unused_apb = ^{paddr[31:5], paddr[1:0]};

   // clr is a strobe on the completing edge so it acts together with the write
   assign clr = wr_stb & (reg_sel == REG_CTRL) & pwdata[CTRL_CLR];

   always_comb begin
      rdata = '0;
      case (reg_sel)
         REG_CTRL:      rdata = {16'd0, thr, 5'd0, stop_on_err, 1'b0, en};
         REG_EXP_LEN:   rdata = exp_len;
         REG_SEED:      rdata = 32'(seed);
         REG_BEAT_CNT:  rdata = 32'(beat_cnt);
         REG_PKT_CNT:   rdata = 32'(pkt_cnt);
         REG_ERR_CNT:   rdata = 32'(err_cnt);
         REG_STATUS:    rdata = status;
         REG_FIRST_ERR: rdata = 32'(first_err);
         default:       rdata = '0;
      endcase
   end

   always_ff @(posedge ACLK or negedge RSTN) begin
      if (!RSTN) begin
         pready <= 1'b0;
         prdata <= '0;
      end else begin
         pready <= access & ~pready;
         prdata <= rd_stb ? rdata : '0;
      end
   end

   always_ff @(posedge ACLK or negedge RSTN) begin
      if (!RSTN) begin
         en          <= 1'b0;
         stop_on_err <= 1'b0;
         thr         <= '0;
         exp_len     <= '0;
         seed        <= '0;
      end else if (wr_stb) begin
         case (reg_sel)
            REG_CTRL: begin
               en          <= pwdata[CTRL_EN];
               stop_on_err <= pwdata[CTRL_STOP];
               thr         <= pwdata[CTRL_THR_MSB:CTRL_THR_LSB];
            end
            REG_EXP_LEN: exp_len <= pwdata;
            REG_SEED:    seed    <= pwdata[DATA_W-1:0];
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/axi4_stream_checker.sv
// AXI4-Stream sink that checks an incrementing data pattern and packet length,
// with throttled TREADY and counters/status exposed over APB.
module axi4_stream_checker
   import axi4_stream_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
)(
   input  logic              ACLK,
   input  logic              RSTN,
   input  logic              TVALID,
   output logic              TREADY,
   input  logic [DATA_W-1:0] TDATA,
   input  logic [3:0]        TKEEP,
   input  logic              TLAST,
   input  logic [7:0]        TID,
   input  logic [1:0]        TDEST,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [31:0]       paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr
);

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + (CNT_W+1)'(inc);
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   logic              en, clr, stop_on_err;
   logic [7:0]        thr;
   logic [31:0]       exp_len;
   logic [DATA_W-1:0] seed;

   logic [1:0]        state;
   logic [7:0]        thr_cnt;
   logic [DATA_W-1:0] expected;
   logic [31:0]       bip;
   logic              len_flag_pkt;
   logic [CNT_W-1:0]  beat_cnt, pkt_cnt, err_cnt;
   logic              data_err, len_err;
   logic [DATA_W-1:0] first_err;
   logic [7:0]        last_tid;
   logic [1:0]        last_tdest;
   logic [3:0]        last_tkeep;
   logic [31:0]       status;

   logic              throttle, beat, data_miss, len_miss;
   logic [31:0]       bip_inc;
   logic [1:0]        err_inc;

   apb_csr_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_csr (
      .ACLK        (ACLK),
      .RSTN        (RSTN),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .prdata      (prdata),
      .pready      (pready),
      .pslverr     (pslverr),
      .en          (en),
      .clr         (clr),
      .stop_on_err (stop_on_err),
      .thr         (thr),
      .exp_len     (exp_len),
      .seed        (seed),
      .beat_cnt    (beat_cnt),
      .pkt_cnt     (pkt_cnt),
      .err_cnt     (err_cnt),
      .status      (status),
      .first_err   (first_err)
   );

   assign throttle = (thr != 8'd0) && (thr_cnt == thr);
   assign TREADY   = (state == ST_RUN) && !throttle;
   assign beat     = TVALID & TREADY;
   assign bip_inc  = bip + 32'd1;

   // A packet reports at most one length error: early overrun or wrong TLAST
   assign data_miss = TDATA != expected;
   assign len_miss  = beat && (exp_len != 32'd0) && !len_flag_pkt &&
                      (TLAST ? (bip_inc != exp_len) : (bip_inc == exp_len));
   assign err_inc   = {1'b0, beat & data_miss} + {1'b0, len_miss};

   assign status = {8'd0, last_tkeep, 2'd0, last_tdest, last_tid,
                    5'd0, len_err, data_err, state == ST_HALT};

   always_ff @(posedge ACLK or negedge RSTN) begin
      if (!RSTN)
         thr_cnt <= '0;
      else if (thr == 8'd0 || thr_cnt >= thr)
         thr_cnt <= '0;
      else
         thr_cnt <= thr_cnt + 8'd1;
   end

   always_ff @(posedge ACLK or negedge RSTN) begin
      if (!RSTN)
         state <= ST_IDLE;
      else if (clr)
         state <= ST_IDLE;
      else begin
         case (state)
            ST_IDLE: if (en) state <= ST_RUN;
            ST_RUN: begin
               if (stop_on_err && err_inc != 2'd0) state <= ST_HALT;
               else if (!en)                       state <= ST_IDLE;
            end
            ST_HALT: state <= ST_HALT;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A mismatching beat resyncs the pattern to the received word
   always_ff @(posedge ACLK or negedge RSTN) begin
      if (!RSTN)
         expected <= '0;
      else if (clr || (state == ST_IDLE && en))
         expected <= seed;
      else if (beat)
         expected <= data_miss ? TDATA + 1'b1 : expected + 1'b1;
   end

   always_ff @(posedge ACLK or negedge RSTN) begin
      if (!RSTN || clr) begin
         beat_cnt     <= '0;
         pkt_cnt      <= '0;
         err_cnt      <= '0;
         bip          <= '0;
         len_flag_pkt <= 1'b0;
         data_err     <= 1'b0;
         len_err      <= 1'b0;
         first_err    <= '0;
         last_tid     <= '0;
         last_tdest   <= '0;
         last_tkeep   <= '0;
      end else if (beat) begin
         beat_cnt     <= sat_add(beat_cnt, 2'd1);
         err_cnt      <= sat_add(err_cnt, err_inc);
         if (TLAST) pkt_cnt <= sat_add(pkt_cnt, 2'd1);
         bip          <= TLAST ? 32'd0 : bip_inc;
         len_flag_pkt <= TLAST ? 1'b0 : (len_flag_pkt | len_miss);
         if (data_miss) data_err <= 1'b1;
         if (data_miss && !data_err) first_err <= TDATA;
         if (len_miss) len_err <= 1'b1;
         last_tid     <= TID;
         last_tdest   <= TDEST;
         last_tkeep   <= TKEEP;
      end
   end

endmodule
